// File: rtl/stream_mux_n.sv
// stream_mux_n: N:1 registered valid/ready stream mux, explicit select or round-robin.
// Define STREAM_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_n #(
   parameter int WIDTH   = 32,
   parameter int NUM_IN  = 4,
   parameter int MODE_RR = 0,
   parameter int SEL_W   = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_last,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [SEL_W-1:0]        out_src,
   input  logic                    out_ready
);

   logic             vld_p0;
   logic [WIDTH-1:0] data_p0;
   logic             last_p0;
   logic [SEL_W-1:0] src_p0;
   logic [SEL_W-1:0] rr_ptr;

   logic             arb_vld;
   logic [SEL_W-1:0] arb_gnt;
   logic [SEL_W-1:0] idx;
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt;
   logic [WIDTH-1:0] gnt_data;
   logic             gnt_last;
   logic             load_en;
   logic             accept;

   // Arbitration: explicit select, or first valid channel after rr_ptr
   always_comb begin
      arb_vld = 1'b0;
      arb_gnt = '0;
      idx     = '0;
      if (MODE_RR == 0) begin
         if (int'(sel) < NUM_IN) begin
            if (in_valid[sel]) begin
               arb_vld = 1'b1;
               arb_gnt = sel;
            end
         end
      end else begin
         for (int k = 1; k <= NUM_IN; k++) begin
            idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!arb_vld && in_valid[idx]) begin
               arb_vld = 1'b1;
               arb_gnt = idx;
            end
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   logic             locked;
   logic [SEL_W-1:0] lock_ch;

   always_comb begin
      gnt_vld = arb_vld;
      gnt     = arb_gnt;
      if (locked) begin
         gnt     = lock_ch;
         gnt_vld = in_valid[lock_ch];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked  <= 1'b0;
         lock_ch <= '0;
      end else if (accept) begin
         locked  <= !gnt_last;
         lock_ch <= gnt;
      end
   end
`else
   assign gnt_vld = arb_vld;
   assign gnt     = arb_gnt;
`endif

   assign gnt_data = in_data[int'(gnt)*WIDTH +: WIDTH];
   assign gnt_last = in_last[gnt];
   assign load_en  = !vld_p0 || out_ready;
   assign accept   = rst_n && gnt_vld && load_en;

   always_comb begin
      in_ready = '0;
      if (accept) in_ready[gnt] = 1'b1;
   end

   // Output stage p0: one-deep register, payload loads only on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         last_p0 <= 1'b0;
         src_p0  <= '0;
         rr_ptr  <= SEL_W'(NUM_IN - 1);
      end else begin
         if (load_en) vld_p0 <= accept;
         if (accept) begin
            data_p0 <= gnt_data;
            last_p0 <= gnt_last;
            src_p0  <= gnt;
            rr_ptr  <= gnt;
         end
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign out_last  = last_p0;
   assign out_src   = src_p0;

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: select mode, round-robin mode, out-of-range select.
// Packet-lock expectations are compiled in when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_n;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [1:0]  src;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   beat_t qa[$];
   beat_t qb[$];

   // instance A: explicit select, 4 channels
   logic [3:0]   a_in_valid = '0, a_in_last = '0, a_in_ready;
   logic [127:0] a_in_data = '0;
   logic [1:0]   a_sel = '0, a_out_src;
   logic         a_out_valid, a_out_last, a_out_ready = 1'b0;
   logic [31:0]  a_out_data;

   // instance B: round-robin, 4 channels
   logic [3:0]   b_in_valid = '0, b_in_last = '0, b_in_ready;
   logic [127:0] b_in_data = '0;
   logic [1:0]   b_sel = '0, b_out_src;
   logic         b_out_valid, b_out_last, b_out_ready = 1'b0;
   logic [31:0]  b_out_data;

   // instance C: explicit select, 5 channels (3-bit sel can go out of range)
   logic [4:0]   c_in_valid = '0, c_in_last = '0, c_in_ready;
   logic [159:0] c_in_data = '0;
   logic [2:0]   c_sel = '0, c_out_src;
   logic         c_out_valid, c_out_last, c_out_ready = 1'b0;
   logic [31:0]  c_out_data;

   stream_mux_n #(.WIDTH(32), .NUM_IN(4), .MODE_RR(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_last(a_in_last), .in_ready(a_in_ready), .sel(a_sel),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
      .out_src(a_out_src), .out_ready(a_out_ready));

   stream_mux_n #(.WIDTH(32), .NUM_IN(4), .MODE_RR(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_last(b_in_last), .in_ready(b_in_ready), .sel(b_sel),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
      .out_src(b_out_src), .out_ready(b_out_ready));

   stream_mux_n #(.WIDTH(32), .NUM_IN(5), .MODE_RR(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
      .in_last(c_in_last), .in_ready(c_in_ready), .sel(c_sel),
      .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
      .out_src(c_out_src), .out_ready(c_out_ready));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] d, input logic l, input logic [1:0] s);
      beat_t b;
      b.data = d; b.last = l; b.src = s;
      qa.push_back(b);
   endtask

   task automatic push_b(input logic [31:0] d, input logic l, input logic [1:0] s);
      beat_t b;
      b.data = d; b.last = l; b.src = s;
      qb.push_back(b);
   endtask

   // monitors: pop one expected beat per transfer
   always @(negedge clk) begin
      if (a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_beat", 64'({a_out_data, a_out_last, a_out_src}), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            beat_t e;
            e = qa.pop_front();
            check("a_beat", 64'({a_out_data, a_out_last, a_out_src}), 64'({e.data, e.last, e.src}));
         end
      end
   end

   always @(negedge clk) begin
      if (b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_beat", 64'({b_out_data, b_out_last, b_out_src}), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            beat_t e;
            e = qb.pop_front();
            check("b_beat", 64'({b_out_data, b_out_last, b_out_src}), 64'({e.data, e.last, e.src}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded bound", $time);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("a_reset_outputs", 64'({a_out_valid, a_out_data, a_out_last, a_out_src}), 64'd0);
      check("b_reset_outputs", 64'({b_out_valid, b_out_data, b_out_last, b_out_src}), 64'd0);

      // ---- A: select channel 2 ----
      step();
      a_sel = 2'd2; a_in_valid = 4'b0100; a_in_last = 4'b0100;
      a_in_data[2*32 +: 32] = 32'hA5A5_0002; a_out_ready = 1'b1;
      #1;
      check("a_in_ready_sel2", 64'(a_in_ready), 64'(4'b0100));
      push_a(32'hA5A5_0002, 1'b1, 2'd2);
      step();
      a_in_valid = 4'b0000;
      check("a_out_src_sel2", 64'({a_out_valid, a_out_src}), 64'({1'b1, 2'd2}));
      step();

      // ---- A: backpressure ----
      a_out_ready = 1'b0; a_sel = 2'd0; a_in_valid = 4'b0001; a_in_last = 4'b0000;
      a_in_data[31:0] = 32'h0000_0011;
      push_a(32'h0000_0011, 1'b0, 2'd0);
      step();
      a_in_data[31:0] = 32'h0000_0022; a_in_last = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("a_stall_in_ready", 64'(a_in_ready), 64'd0);
         check("a_stall_hold", 64'({a_out_valid, a_out_data, a_out_src}), 64'({1'b1, 32'h11, 2'd0}));
         step();
      end
      a_out_ready = 1'b1;
      push_a(32'h0000_0022, 1'b1, 2'd0);
      step();
      a_in_valid = 4'b0000;
      check("a_no_bubble", 64'({a_out_valid, a_out_data}), 64'({1'b1, 32'h22}));
      repeat (2) step();

      // ---- C: out-of-range select never grants ----
      c_sel = 3'd5; c_in_valid = 5'b11111; c_out_ready = 1'b1; c_in_last = 5'b11111;
      for (int i = 0; i < 5; i++) c_in_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
      #1;
      check("c_sel5_in_ready", 64'(c_in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("c_sel5_out", 64'({c_out_valid, c_in_ready}), 64'd0);
      end
      c_sel = 3'd4;
      #1;
      check("c_sel4_in_ready", 64'(c_in_ready), 64'(5'b10000));
      step();
      c_in_valid = 5'b00000;
      check("c_sel4_out", 64'({c_out_valid, c_out_data, c_out_src}), 64'({1'b1, 32'hC000_0004, 3'd4}));
      repeat (2) step();

      // ---- B: round-robin, all valid ----
      b_out_ready = 1'b1; b_in_last = 4'b1111;
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      b_in_valid = 4'b1111;
      push_b(32'hB000_0000, 1'b1, 2'd0);
      push_b(32'hB000_0001, 1'b1, 2'd1);
      push_b(32'hB000_0002, 1'b1, 2'd2);
      push_b(32'hB000_0003, 1'b1, 2'd3);
      push_b(32'hB000_0000, 1'b1, 2'd0);
      repeat (5) step();
      b_in_valid = 4'b1010;
      push_b(32'hB000_0001, 1'b1, 2'd1);
      push_b(32'hB000_0003, 1'b1, 2'd3);
      push_b(32'hB000_0001, 1'b1, 2'd1);
      push_b(32'hB000_0003, 1'b1, 2'd3);
      repeat (4) step();
      b_in_valid = 4'b0000;
      repeat (2) step();

      // ch0 alone leaves rr_ptr at 0
      b_in_valid = 4'b0001;
      push_b(32'hB000_0000, 1'b1, 2'd0);
      step();
`ifdef STREAM_MUX_LOCK_EN
      // ---- B: packet lock on ch1 ----
      b_in_valid = 4'b0111; b_in_last = 4'b0101;
      b_in_data[1*32 +: 32] = 32'hC100_0001;
      push_b(32'hC100_0001, 1'b0, 2'd1);
      step();
      b_in_valid = 4'b0101;
      #1;
      check("b_lock_stall_ready", 64'(b_in_ready), 64'd0);
      step();
      check("b_lock_stall_out", 64'({b_out_valid, b_in_ready}), 64'd0);
      step();
      b_in_valid = 4'b0111;
      b_in_data[1*32 +: 32] = 32'hC100_0002;
      push_b(32'hC100_0002, 1'b0, 2'd1);
      step();
      b_in_data[1*32 +: 32] = 32'hC100_0003; b_in_last = 4'b0111;
      push_b(32'hC100_0003, 1'b1, 2'd1);
      step();
      push_b(32'hB000_0002, 1'b1, 2'd2);
      step();
`else
      // ---- B: no lock, in_last=0 does not hold the grant ----
      b_in_valid = 4'b0111; b_in_last = 4'b0000;
      push_b(32'hB000_0001, 1'b0, 2'd1);
      push_b(32'hB000_0002, 1'b0, 2'd2);
      push_b(32'hB000_0000, 1'b0, 2'd0);
      repeat (3) step();
`endif
      b_in_valid = 4'b0000; b_in_last = 4'b1111;
      repeat (2) step();

      // ---- B: reset while a beat is held ----
      b_out_ready = 1'b0; b_in_valid = 4'b0001;
      b_in_data[31:0] = 32'h0000_0033;
      step();
      check("b_held_33", 64'({b_out_valid, b_out_data, b_in_ready}), 64'({1'b1, 32'h33, 4'b0000}));
      #1;
      rst_n = 1'b0;
      #1;
      check("b_reset_mid_out", 64'({b_out_valid, b_out_data, b_out_last, b_out_src}), 64'd0);
      check("b_reset_mid_ready", 64'(b_in_ready), 64'd0);
      step();
      rst_n = 1'b1;
      b_in_valid = 4'b1111; b_out_ready = 1'b1;
      b_in_data[31:0] = 32'hB000_0000;
      push_b(32'hB000_0000, 1'b1, 2'd0);
      step();
      b_in_valid = 4'b0000;
      repeat (3) step();

      check("a_queue_drained", 64'(qa.size()), 64'd0);
      check("b_queue_drained", 64'(qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
